// File: rtl/nes_vga_pkg.sv
// rtl/nes_vga_pkg.sv - shared timing defaults, types and NES palette for VGA scanout
//
// Purpose: default VGA timing for the 12.5 MHz half-resolution mode, the pixel
// and palette-index types, the per-pixel sync/window bundle carried down the
// alignment pipeline, and the 64-entry NES palette as 12-bit RGB.
// Ports: none (package).

package nes_vga_pkg;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_H_SYNC   = 48;
  localparam int DEF_H_BP     = 24;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // NES frame width in pixels; the window is this many columns wide.
  localparam int NES_WIDTH = 256;

  typedef logic [11:0] rgb12_t;
  typedef logic [5:0]  pal_idx_t;

  // Per-pixel flags decoded from the counters and delayed to the pixel output.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic active;
    logic win;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, active: 1'b0, win: 1'b0};

  // NES 2C02 palette reduced to 4 bits per channel, {R,G,B}.
  localparam rgb12_t NES_PALETTE [64] = '{
    12'h777, 12'h024, 12'h009, 12'h409, 12'h806, 12'hA02, 12'hA00, 12'h710,
    12'h530, 12'h050, 12'h060, 12'h040, 12'h044, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h06D, 12'h04F, 12'h80F, 12'hC0C, 12'hF06, 12'hF00, 12'hC40,
    12'h960, 12'h290, 12'h0A0, 12'h081, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'hA6F, 12'hF4F, 12'hF6B, 12'hF74, 12'hFA4,
    12'hFC0, 12'hBF1, 12'h5F4, 12'h4FA, 12'h0FE, 12'h555, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFBD, 12'hFCB, 12'hFDA,
    12'hFEA, 12'hDF8, 12'hBFB, 12'hAFD, 12'h0FF, 12'hCCC, 12'h000, 12'h000
  };

endpackage

// File: rtl/nes_vga_scanout_palette.sv
// rtl/nes_vga_scanout_palette.sv - registered 64-entry NES palette ROM
//
// Purpose: maps a 6-bit palette index to 12-bit RGB with one clock of latency.
// Ports:
//   clk  in   pixel clock
//   idx  in   palette index (pal_idx_t)
//   rgb  out  registered colour (rgb12_t), valid one clock after idx

import nes_vga_pkg::*;

module nes_palette (
  input  logic     clk,
  input  pal_idx_t idx,
  output rgb12_t   rgb
);

  // No reset: the output is only used when the delayed window flag is set,
  // and that flag is cleared by reset.
  always_ff @(posedge clk) begin
    rgb <= NES_PALETTE[idx];
  end

endmodule

// File: rtl/nes_vga_scanout.sv
// rtl/nes_vga_scanout.sv - VGA timing, NES frame-buffer fetch and pixel output
//
// Purpose: generates 400x525 VGA timing from the 12.5 MHz pixel clock, fetches
// the 256x240 NES frame buffer centred horizontally with each NES row shown on
// two VGA lines, maps indices through the NES palette and keeps sync aligned to
// the pixel stream across the frame-buffer and palette latency.
// Ports:
//   clk          in   pixel clock
//   reset        in   synchronous, active-high
//   fb_rd        out  frame-buffer read strobe
//   fb_addr      out  {nes_y[7:0], nes_x[7:0]}
//   fb_data      in   palette index, valid RD_LAT clocks after fb_rd
//   vga_hs       out  hsync, active low
//   vga_vs       out  vsync, active low
//   vga_de       out  display enable
//   vga_rgb      out  {R,G,B} 4 bits each
//   frame_start  out  one-clock pulse at h=0, v=0 (fetch timing)
//   vblank       out  high while v >= V_ACTIVE (fetch timing)

import nes_vga_pkg::*;

module nes_vga_scanout #(
  parameter int     H_ACTIVE   = DEF_H_ACTIVE,
  parameter int     H_FP       = DEF_H_FP,
  parameter int     H_SYNC     = DEF_H_SYNC,
  parameter int     H_BP       = DEF_H_BP,
  parameter int     V_ACTIVE   = DEF_V_ACTIVE,
  parameter int     V_FP       = DEF_V_FP,
  parameter int     V_SYNC     = DEF_V_SYNC,
  parameter int     V_BP       = DEF_V_BP,
  parameter int     X_OFFSET   = 32,
  parameter int     RD_LAT     = 2,
  parameter rgb12_t BORDER_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fb_rd,
  output logic [15:0] fb_addr,
  input  logic [5:0]  fb_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [11:0] vga_rgb,
  output logic        frame_start,
  output logic        vblank
);

  localparam int LINE_CLKS   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Clocks from the fetch outputs to the pixel outputs.
  localparam int LAT = RD_LAT + 1;

  // h/v name the pixel whose fetch-stage outputs are loaded on the next edge.
  logic [8:0] h;
  logic [9:0] v;
  logic       h_last;
  logic       v_last;

  assign h_last = (h == 9'(LINE_CLKS - 1));
  assign v_last = (v == 10'(FRAME_LINES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 10'd1;
    end else begin
      h <= h + 9'd1;
    end
  end

  // Stage-0 decode of the counter position.
  int         hi;
  int         vi;
  sync_t      dec;
  logic [7:0] xrel;
  logic [15:0] addr_d;
  logic       fs_d;
  logic       vb_d;

  always_comb begin
    hi          = int'(h);
    vi          = int'(v);
    dec         = SYNC_IDLE;
    dec.active  = (hi < H_ACTIVE) && (vi < V_ACTIVE);
    dec.win     = dec.active && (hi >= X_OFFSET) && (hi < X_OFFSET + NES_WIDTH);
    dec.hs_n    = !((hi >= H_ACTIVE + H_FP) && (hi < H_ACTIVE + H_FP + H_SYNC));
    dec.vs_n    = !((vi >= V_ACTIVE + V_FP) && (vi < V_ACTIVE + V_FP + V_SYNC));
    xrel        = 8'(h - 9'(X_OFFSET));
    // v[8:1] selects the NES row, so VGA lines 2k and 2k+1 repeat row k.
    addr_d      = dec.win ? {v[8:1], xrel} : 16'h0000;
    fs_d        = (h == 9'd0) && (v == 10'd0);
    vb_d        = (vi >= V_ACTIVE);
  end

  // Fetch stage: read strobe/address plus the flags for this pixel.
  sync_t s0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_rd       <= 1'b0;
      fb_addr     <= 16'h0000;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      s0          <= SYNC_IDLE;
    end else begin
      fb_rd       <= dec.win;
      fb_addr     <= addr_d;
      frame_start <= fs_d;
      vblank      <= vb_d;
      s0          <= dec;
    end
  end

  // Delay the flags by LAT clocks so they land with the palette output.
  sync_t dly [LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        dly[i] <= SYNC_IDLE;
      end
    end else begin
      dly[0] <= s0;
      for (int i = 1; i < LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  rgb12_t pal_rgb;

  nes_palette u_palette (
    .clk (clk),
    .idx (fb_data),
    .rgb (pal_rgb)
  );

  sync_t px;
  assign px = dly[LAT-1];

  assign vga_hs = px.hs_n;
  assign vga_vs = px.vs_n;
  assign vga_de = px.active;

  // fb_data outside the window is garbage; the window flag masks it here.
  always_comb begin
    vga_rgb = 12'h000;
    if (px.win) begin
      vga_rgb = pal_rgb;
    end else if (px.active) begin
      vga_rgb = BORDER_RGB;
    end
  end

endmodule

// File: tb/tb_nes_vga_scanout.sv
// tb/tb_nes_vga_scanout.sv - self-checking bench for nes_vga_scanout

module tb_nes_vga_scanout;

  localparam int H_ACTIVE = 320;
  localparam int H_FP     = 8;
  localparam int H_SYNC   = 48;
  localparam int H_BP     = 24;
  localparam int H_TOTAL  = 400;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_TOTAL  = 14;
  localparam int X_OFF    = 32;
  localparam int RD_LAT   = 2;
  localparam int LAT      = 3;
  localparam logic [11:0] BORDER = 12'h00F;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clk;
  logic        reset;
  logic        fb_rd;
  logic [15:0] fb_addr;
  logic [5:0]  fb_data;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [11:0] vga_rgb;
  logic        frame_start;
  logic        vblank;

  int vectors;
  int miscompares;
  int hr;
  int vr;

  nes_vga_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .X_OFFSET(X_OFF), .RD_LAT(RD_LAT), .BORDER_RGB(BORDER)
  ) dut (
    .clk(clk), .reset(reset), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .fb_data(fb_data), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_rgb(vga_rgb), .frame_start(frame_start), .vblank(vblank)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] data_for(input logic [15:0] a);
    case ((int'(a[7:0]) + int'(a[15:8])) % 5)
      0:       return 6'h30;
      1:       return 6'h12;
      2:       return 6'h16;
      3:       return 6'h2A;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [11:0] idx_rgb(input logic [5:0] i);
    case (i)
      6'h30:   return 12'hFFF;
      6'h12:   return 12'h04F;
      6'h16:   return 12'hF00;
      6'h2A:   return 12'h5F4;
      6'h00:   return 12'h777;
      default: return 12'hBAD;
    endcase
  endfunction

  // Frame buffer: answers each read RD_LAT clocks later; garbage when idle.
  task automatic fb_model();
    logic [16:0] hist [5];
    for (int i = 0; i < 5; i++) hist[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {fb_rd, fb_addr};
      if (hist[RD_LAT][16]) fb_data = data_for(hist[RD_LAT][15:0]);
      else fb_data = 6'h20;
    end
  endtask

  // Scoreboard: reference position, fetch-stage check and delayed pixel queue.
  task automatic monitor_loop();
    logic        r;
    logic        started;
    logic        e_act, e_win, e_hs, e_vs;
    logic [15:0] e_addr;
    logic [11:0] e_rgb;
    logic [18:0] exp_s0, got_s0;
    logic [14:0] exp_v, got_v;
    logic [14:0] q [$];
    started = 1'b0;
    forever begin
      @(posedge clk);
      r = reset;
      @(negedge clk);
      if (r) begin
        started = 1'b1;
        hr = 0;
        vr = 0;
        q.delete();
        for (int i = 0; i < LAT; i++) q.push_back({1'b1, 1'b1, 1'b0, 12'h000});
        got_s0 = {fb_rd, fb_addr, frame_start, vblank};
        got_v  = {vga_hs, vga_vs, vga_de, vga_rgb};
        vectors++;
        if (got_s0 !== 19'h0 || got_v !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
          miscompares++;
          $display("FAIL reset_hold: got %h/%h want 00000/%h", got_s0, got_v, {3'b110, 12'h000});
        end
      end else if (started) begin
        e_act  = (hr < H_ACTIVE) && (vr < V_ACTIVE);
        e_win  = e_act && (hr >= X_OFF) && (hr < X_OFF + 256);
        e_hs   = !((hr >= H_ACTIVE + H_FP) && (hr < H_ACTIVE + H_FP + H_SYNC));
        e_vs   = !((vr >= V_ACTIVE + V_FP) && (vr < V_ACTIVE + V_FP + V_SYNC));
        e_addr = e_win ? 16'((vr / 2) * 256 + (hr - X_OFF)) : 16'h0000;
        e_rgb  = e_win ? idx_rgb(data_for(e_addr)) : (e_act ? BORDER : 12'h000);
        exp_s0 = {e_win, e_addr, (hr == 0 && vr == 0), (vr >= V_ACTIVE)};
        got_s0 = {fb_rd, fb_addr, frame_start, vblank};
        vectors++;
        if (got_s0 !== exp_s0) begin
          miscompares++;
          $display("FAIL fetch h=%0d v=%0d: got %h want %h", hr, vr, got_s0, exp_s0);
        end
        q.push_back({e_hs, e_vs, e_act, e_rgb});
        exp_v = q.pop_front();
        got_v = {vga_hs, vga_vs, vga_de, vga_rgb};
        vectors++;
        if (got_v !== exp_v) begin
          miscompares++;
          $display("FAIL pixel h=%0d v=%0d: got %h want %h", hr, vr, got_v, exp_v);
        end
        hr++;
        if (hr == H_TOTAL) begin
          hr = 0;
          vr++;
          if (vr == V_TOTAL) vr = 0;
        end
      end
    end
  endtask

  task automatic wait_pos(input int wv, input int wh, output bit found);
    found = 1'b0;
    for (int i = 0; i < FRAME + 2; i++) begin
      @(posedge clk);
      #1;
      if (hr == wh && vr == wv) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if ({fb_rd, fb_addr, vga_hs, vga_vs, vga_de, vga_rgb, frame_start, vblank} !==
        {1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 12'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: rd=%b addr=%h hs=%b vs=%b de=%b rgb=%h fs=%b vb=%b", fb_rd, fb_addr,
               vga_hs, vga_vs, vga_de, vga_rgb, frame_start, vblank);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (frame_start !== 1'b1 || fb_rd !== 1'b0 || vga_de !== 1'b0) begin
      miscompares++;
      $display("FAIL first_clock: fs=%b rd=%b de=%b want 1 0 0", frame_start, fb_rd, vga_de);
    end
    n = 0;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) begin
        n = c;
        break;
      end
    end
    vectors++;
    if (n != FRAME) begin
      miscompares++;
      $display("FAIL frame_period: got %0d want %0d", n, FRAME);
    end
  endtask

  task automatic test_line();
    bit   found;
    int   low;
    int   fall_h;
    logic prev;
    wait_pos(1, 0, found);
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL line_wait: got timeout want h=0");
    end
    low    = 0;
    fall_h = -1;
    prev   = vga_hs;
    for (int c = 0; c < H_TOTAL; c++) begin
      if (vga_hs === 1'b0) low++;
      if (prev === 1'b1 && vga_hs === 1'b0) fall_h = hr;
      prev = vga_hs;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (low != H_SYNC) begin
      miscompares++;
      $display("FAIL hsync_width: got %0d want %0d", low, H_SYNC);
    end
    vectors++;
    if (fall_h != H_ACTIVE + H_FP + LAT) begin
      miscompares++;
      $display("FAIL hsync_fall: got h=%0d want %0d", fall_h, H_ACTIVE + H_FP + LAT);
    end
  endtask

  task automatic test_frame();
    int   n, vs_low, vb_high, extra, fall_h, fall_v;
    logic prev;
    n = 0;
    for (int c = 0; c < FRAME + 2; c++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) begin
        n = 1;
        break;
      end
    end
    vectors++;
    if (n == 0) begin
      miscompares++;
      $display("FAIL frame_wait: got timeout want frame_start");
    end
    vs_low = 0; vb_high = 0; extra = 0; fall_h = -1; fall_v = -1;
    prev = vga_vs;
    for (int c = 1; c <= FRAME; c++) begin
      @(posedge clk);
      #1;
      if (vga_vs === 1'b0) vs_low++;
      if (vblank === 1'b1) vb_high++;
      if (prev === 1'b1 && vga_vs === 1'b0) begin
        fall_h = hr;
        fall_v = vr;
      end
      prev = vga_vs;
      if (c < FRAME && frame_start !== 1'b0) extra++;
    end
    vectors++;
    if (frame_start !== 1'b1 || extra != 0) begin
      miscompares++;
      $display("FAIL frame_repeat: got fs=%b extra=%0d want 1 0", frame_start, extra);
    end
    vectors++;
    if (vs_low != V_SYNC * H_TOTAL) begin
      miscompares++;
      $display("FAIL vsync_width: got %0d want %0d", vs_low, V_SYNC * H_TOTAL);
    end
    vectors++;
    if (fall_h != LAT || fall_v != V_ACTIVE + V_FP) begin
      miscompares++;
      $display("FAIL vsync_fall: got h=%0d v=%0d want %0d %0d", fall_h, fall_v, LAT, V_ACTIVE + V_FP);
    end
    vectors++;
    if (vb_high != (V_TOTAL - V_ACTIVE) * H_TOTAL) begin
      miscompares++;
      $display("FAIL vblank_len: got %0d want %0d", vb_high, (V_TOTAL - V_ACTIVE) * H_TOTAL);
    end
  endtask

  task automatic test_addressing();
    int          tv [8] = '{0, 0, 0, 0, 1, 2, 7, 8};
    int          th [8] = '{31, 32, 287, 288, 32, 33, 32, 32};
    logic [16:0] te [8] = '{17'h00000, 17'h10000, 17'h100FF, 17'h00000,
                            17'h10000, 17'h10101, 17'h10300, 17'h00000};
    bit found;
    for (int i = 0; i < 8; i++) begin
      wait_pos(tv[i], th[i], found);
      vectors++;
      if (!found || {fb_rd, fb_addr} !== te[i]) begin
        miscompares++;
        $display("FAIL addr v=%0d h=%0d: got %h found=%b want %h", tv[i], th[i], {fb_rd, fb_addr},
                 found, te[i]);
      end
    end
  endtask

  task automatic test_datapath();
    int          tv [8] = '{0, 0, 0, 0, 0, 0, 0, 2};
    int          th [8] = '{8, 34, 35, 36, 37, 291, 323, 35};
    logic [12:0] te [8] = '{{1'b1, 12'h00F}, {1'b1, 12'h00F}, {1'b1, 12'hFFF}, {1'b1, 12'h04F},
                            {1'b1, 12'hF00}, {1'b1, 12'h00F}, {1'b0, 12'h000}, {1'b1, 12'h04F}};
    bit found;
    for (int i = 0; i < 8; i++) begin
      wait_pos(tv[i], th[i], found);
      vectors++;
      if (!found || {vga_de, vga_rgb} !== te[i]) begin
        miscompares++;
        $display("FAIL pixel_path v=%0d h=%0d: got %h found=%b want %h", tv[i], th[i],
                 {vga_de, vga_rgb}, found, te[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit found;
    wait_pos(5, 150, found);
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midreset_wait: got timeout want v=5 h=150");
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if ({fb_rd, vga_de, frame_start, vga_hs, vga_rgb} !== {1'b0, 1'b0, 1'b0, 1'b1, 12'h000}) begin
      miscompares++;
      $display("FAIL midreset_clear: got rd=%b de=%b fs=%b hs=%b rgb=%h want 0 0 0 1 000",
               fb_rd, vga_de, frame_start, vga_hs, vga_rgb);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({frame_start, vga_de, fb_rd} !== 3'b100) begin
      miscompares++;
      $display("FAIL midreset_restart: got fs=%b de=%b rd=%b want 1 0 0", frame_start, vga_de, fb_rd);
    end
  endtask

  initial begin
    reset       = 1'b1;
    fb_data     = 6'h00;
    vectors     = 0;
    miscompares = 0;
    hr          = 0;
    vr          = 0;
    fork
      monitor_loop();
      fb_model();
    join_none
    test_reset();
    test_line();
    test_frame();
    test_addressing();
    test_datapath();
    test_reset_midframe();
    test_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
